if_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the MIPS pipeline: owns the PC, issues word fetches to instruction memory over a valid/ready request channel that tolerates variable latency, and buffers returned instructions with their PCs in a DEPTH-entry queue that feeds ID through a valid/ready handshake. Branch and jump redirects from ID flush the queue and discard any responses still in flight from the old path. It replaces the single-register PC/freeze fetch stage; the ID stall becomes back-pressure on the output handshake.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 tb/tb_if_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared MIPS pipeline constants, opcodes and the jump-target helper.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WORD_LEN    = 32;
    localparam int INSTR_BYTES = 4;
    localparam int JUMP_OFF_W  = 26;

    // Opcodes ID decodes to raise jump_taken / branch_taken
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    function automatic logic [WORD_LEN-1:0] jump_target(
        input logic [WORD_LEN-1:0]   pc4,
        input logic [JUMP_OFF_W-1:0] off
    );
        return {pc4[WORD_LEN-1:JUMP_OFF_W+2], off, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO with synchronous clear and registered head output.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_pop;
    logic             w_push;

    assign w_pop   = pop_i && (count_q != '0);
    assign w_push  = push_i && ((count_q != c_depth) || w_pop);
    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (w_push && !w_pop)      count_q <= count_q + CW'(1);
            else if (!w_push && w_pop) count_q <= count_q - CW'(1);
        end
    end

    // Storage needs no reset: only entries below count_q are ever observed
    always_ff @(posedge clk) begin
        if (w_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push_i && !clear_i && (count_q == c_depth) && !w_pop));

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction fetch stage: PC, credit-limited imem requests, redirect
//            flush with in-flight response dropping, and a fetch queue to ID.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter int                         WORD_LEN = mips_pkg::WORD_LEN,
    parameter int                         DEPTH    = 4,
    parameter logic [mips_pkg::WORD_LEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_LEN-1:0]           id_pc,
    input  logic                          branch_taken,
    input  logic [WORD_LEN-1:0]           branch_offset,
    input  logic                          jump_taken,
    input  logic [mips_pkg::JUMP_OFF_W-1:0] jump_offset,
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [WORD_LEN-1:0]           imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [WORD_LEN-1:0]           imem_rsp_data,
    output logic                          if_valid,
    input  logic                          if_ready,
    output logic [WORD_LEN-1:0]           if_pc,
    output logic [WORD_LEN-1:0]           if_instr
);

    import mips_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]       c_depth = CW'(DEPTH);
    localparam logic [WORD_LEN-1:0] c_step  = WORD_LEN'(INSTR_BYTES);

    logic [WORD_LEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [WORD_LEN-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [CW-1:0]         w_count;
    logic [CW:0]           w_credit_used;
    logic [WORD_LEN-1:0]   w_pc4;
    logic [WORD_LEN-1:0]   w_target;
    logic                  w_redirect;
    logic                  w_fire;
    logic                  w_push;
    logic                  w_pop;
    logic [2*WORD_LEN-1:0] w_head;

    assign w_redirect = jump_taken | branch_taken;
    assign w_pc4      = id_pc + c_step;
    assign w_target   = jump_taken ? jump_target(w_pc4, jump_offset)
                                   : w_pc4 + (branch_offset << 2);

    // Queue slots already promised: entries held plus responses still owed
    assign w_credit_used  = {1'b0, w_count} + {1'b0, outst_q};
    assign imem_req_valid = !rst && !w_redirect && (w_credit_used < {1'b0, c_depth});
    assign imem_req_addr  = fetch_pc_q;
    assign w_fire         = imem_req_valid && imem_req_ready;

    assign w_push = imem_rsp_valid && (drop_q == '0) && !w_redirect;
    assign w_pop  = if_valid && if_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (w_fire) begin
            fetch_pc_d = fetch_pc_q + c_step;
            outst_d    = outst_d + CW'(1);
        end
        if (imem_rsp_valid) begin
            outst_d = outst_d - CW'(1);
            if (drop_q != '0) drop_d = drop_q - CW'(1);
        end
        if (w_push) rsp_pc_d = rsp_pc_q + c_step;
        // Every response still owed after this cycle belongs to the old path
        if (w_redirect) begin
            fetch_pc_d = w_target;
            rsp_pc_d   = w_target;
            drop_d     = outst_q - {{(CW-1){1'b0}}, imem_rsp_valid};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC[WORD_LEN-1:0];
            rsp_pc_q   <= RESET_PC[WORD_LEN-1:0];
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*WORD_LEN)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (w_redirect),
        .push_i  (w_push),
        .data_i  ({rsp_pc_q, imem_rsp_data}),
        .pop_i   (w_pop),
        .valid_o (if_valid),
        .data_o  (w_head),
        .count_o (w_count)
    );

    assign if_pc    = w_head[2*WORD_LEN-1:WORD_LEN];
    assign if_instr = w_head[WORD_LEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Self-checking bench: variable-latency memory model plus scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] MAGIC    = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] id_pc = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = '0;
    logic        jump_taken = 1'b0;
    logic [25:0] jump_offset = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .WORD_LEN (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_pc          (id_pc),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .jump_taken     (jump_taken),
        .jump_offset    (jump_offset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    typedef struct {
        logic [31:0] id_pc;
        logic        br;
        logic [31:0] boff;
        logic        jmp;
        logic [25:0] joff;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    vec_t        vecs[6];
    mreq_t       memq[$];
    logic [31:0] sb[$];
    int          cyc;
    int          lat;
    int          n_chk;
    int          n_fail;
    int          fires;
    int          pops;
    logic        fire_s;
    logic        pop_s;
    logic [31:0] pop_pc_s;
    logic [31:0] exp_req_addr;
    logic [31:0] redir_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: entered and left at a falling edge with control inputs already set
    task automatic step();
        mreq_t       m;
        logic [31:0] a;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.addr ^ MAGIC;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        fire_s = imem_req_valid & imem_req_ready;
        pop_s  = if_valid & if_ready;
        if (branch_taken | jump_taken)
            chk("req_valid_on_redirect", 32'(imem_req_valid), 32'd0);
        if (pop_s) begin
            pops++;
            pop_pc_s = if_pc;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got pc %h expected no entry (cycle %0d)", if_pc, cyc);
            end else begin
                a = sb.pop_front();
                chk("if_pc", if_pc, a);
                chk("if_instr", if_instr, a ^ MAGIC);
            end
        end
        if (fire_s) begin
            fires++;
            chk("req_addr", imem_req_addr, exp_req_addr);
            memq.push_back('{addr: imem_req_addr, due: cyc + lat});
            sb.push_back(exp_req_addr);
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (branch_taken | jump_taken) begin
            sb.delete();
            exp_req_addr = redir_tgt;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        memq.delete();
        sb.delete();
        branch_taken   = 1'b0;
        jump_taken     = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_req_addr = RESET_PC;
        cyc = 0;
    endtask

    task automatic wait_pop(input int max, output logic found, output int at);
        found = 1'b0;
        at    = -1;
        for (int k = 0; k < max && !found; k++) begin
            step();
            if (pop_s) begin
                found = 1'b1;
                at    = cyc - 1;
            end
        end
    endtask

    initial begin
        logic found;
        int   at;
        int   t_red;

        n_chk = 0; n_fail = 0; cyc = 0; lat = 1; fires = 0; pops = 0;
        exp_req_addr = RESET_PC; redir_tgt = '0; pop_pc_s = '0;
        fire_s = 1'b0; pop_s = 1'b0;

        vecs[0] = '{32'h0000_0040, 1'b1, 32'd3,          1'b0, 26'h0,        32'h0000_0050, 3};
        vecs[1] = '{32'h1000_0000, 1'b1, 32'd5,          1'b1, 26'h10,       32'h1000_0040, 1};
        vecs[2] = '{32'h0000_0100, 1'b1, 32'hFFFF_FFFE,  1'b0, 26'h0,        32'h0000_00FC, 2};
        vecs[3] = '{32'hFFFF_FFFC, 1'b1, 32'd0,          1'b0, 26'h0,        32'h0000_0000, 1};
        vecs[4] = '{32'h2000_0000, 1'b0, 32'd0,          1'b1, 26'h3FF_FFFF, 32'h2FFF_FFFC, 1};
        vecs[5] = '{32'h0000_0080, 1'b1, 32'd1,          1'b0, 26'h0,        32'h0000_0088, 2};

        @(negedge clk);

        // Reset and stream: first fetch at cycle 0, pcs 0,4,8,12 visible from cycle 2
        lat = 1; if_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) chk("first_fire", 32'(fire_s), 32'd1);
            if (i == 1) chk("no_valid_cycle1", 32'(pop_s), 32'd0);
            if (i >= 2 && i <= 5) begin
                chk("stream_valid", 32'(pop_s), 32'd1);
                chk("stream_pc", pop_pc_s, 32'((i - 2) * 4));
            end
        end

        // Back-pressure: exactly DEPTH requests, then drain in order
        lat = 1; if_ready = 1'b0;
        do_reset();
        fires = 0;
        for (int i = 0; i < 10; i++) step();
        chk("bp_fires", 32'(fires), 32'(DEPTH));
        chk("bp_req_valid_low", 32'(imem_req_valid), 32'd0);
        imem_req_ready = 1'b0; if_ready = 1'b1; pops = 0;
        for (int i = 0; i < 8; i++) step();
        chk("bp_drain_pops", 32'(pops), 32'(DEPTH));
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);
        imem_req_ready = 1'b1;

        // Redirect table
        do_reset();
        if_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            lat = vecs[v].lat;
            for (int i = 0; i < 6; i++) step();
            id_pc         = vecs[v].id_pc;
            branch_taken  = vecs[v].br;
            branch_offset = vecs[v].boff;
            jump_taken    = vecs[v].jmp;
            jump_offset   = vecs[v].joff;
            redir_tgt     = vecs[v].exp;
            t_red = cyc;
            step();
            branch_taken = 1'b0; jump_taken = 1'b0;
            step();
            chk("redir_next_fire", 32'(fire_s), 32'd1);
            if (pop_s) chk("redir_early_pop", pop_pc_s, vecs[v].exp);
            wait_pop(40, found, at);
            chk("redir_pop_seen", 32'(found), 32'd1);
            chk("redir_target", pop_pc_s, vecs[v].exp);
            if (lat == 1) chk("redir_latency", 32'(at - t_red), 32'd3);
        end

        // Redirect coinciding with a response while the queue holds entries and pops
        lat = 2;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if_ready = (i % 3 != 0);
            step();
        end
        if_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (memq.size() > 0 && memq[0].due <= cyc && if_valid) found = 1'b1;
            else step();
        end
        chk("collision_setup", 32'(found), 32'd1);
        if_ready = 1'b1;
        id_pc = 32'h0000_0200; branch_offset = 32'h10; branch_taken = 1'b1;
        redir_tgt = 32'h0000_0244;
        step();
        branch_taken = 1'b0;
        wait_pop(40, found, at);
        chk("collision_pop_seen", 32'(found), 32'd1);
        chk("collision_target", pop_pc_s, 32'h0000_0244);

        // Reset mid-flight
        lat = 2; if_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("pre_reset_valid", 32'(if_valid), 32'd1);
        #3;
        do_reset();
        chk("restart_addr", imem_req_addr, RESET_PC);
        if_ready = 1'b1;
        wait_pop(20, found, at);
        chk("restart_pop_seen", 32'(found), 32'd1);
        chk("restart_pc", pop_pc_s, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
